// File: rtl/led_seq_display_pkg.sv
// Shared types and helpers for the SAP3 LED sequence display path.
package led_pkg;
   localparam int DATA_W_DEF  = 8;
   localparam int DWELL_W_DEF = 24;

   typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

   // A zero dwell still shows the value for one cycle.
   function automatic logic [63:0] eff_dwell(input logic [63:0] d);
      return (d == 64'd0) ? 64'd1 : d;
   endfunction
endpackage

// File: rtl/led_seq_display_if.sv
// Producer stream plus LED outputs for led_seq_display; BRIGHT exists only with LED_PWM_EN.
interface led_seq_display_if import led_pkg::*; #(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
);
   logic               in_valid;
   logic [DATA_W-1:0]  in_data;
   logic               in_ready;
   logic [DWELL_W-1:0] dwell;
   logic [DATA_W-1:0]  leds;
   logic               showing;
   logic               done;
`ifdef LED_PWM_EN
   logic [3:0]         bright;

   modport master (output in_valid, in_data, dwell, bright,
                   input  in_ready, leds, showing, done);
   modport slave  (input  in_valid, in_data, dwell, bright,
                   output in_ready, leds, showing, done);
`else
   modport master (output in_valid, in_data, dwell,
                   input  in_ready, leds, showing, done);
   modport slave  (input  in_valid, in_data, dwell,
                   output in_ready, leds, showing, done);
`endif
endinterface

// File: rtl/led_seq_display_fifo.sv
// Synchronous FIFO with registered count; depth must be a power of two so pointers wrap naturally.
module led_fifo #(
   parameter  int DATA_W     = 8,
   parameter  int FIFO_DEPTH = 4,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int CW         = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [CW-1:0]     o_count
);
   logic [FIFO_DEPTH-1:0][DATA_W-1:0] r_mem;
   logic [AW-1:0]                     r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]                     r_count;
   logic                              w_push, w_pop;

   assign o_full  = (r_count == CW'(FIFO_DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/led_seq_display.sv
// Buffers incoming values and shows each on the LEDs for a dwell time, pulsing DONE when drained.
// Define LED_PWM_EN to add BRIGHT-controlled PWM dimming of the LED outputs.
module led_seq_display import led_pkg::*; #(
   parameter  int DATA_W     = DATA_W_DEF,
   parameter  int FIFO_DEPTH = 4,
   parameter  int DWELL_W    = DWELL_W_DEF,
   localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input logic              clk,
   input logic              rst_n,
   led_seq_display_if.slave bus
);
   state_t              r_state;
   logic [DWELL_W-1:0]  r_timer;
   logic [DATA_W-1:0]   r_shown;
   logic                r_done;

   logic                w_full, w_empty, w_push, w_load;
   logic [CW-1:0]       w_count_unused;
   logic [DATA_W-1:0]   w_head, w_shown_nxt;
   logic [DWELL_W-1:0]  w_dwell;

   assign bus.in_ready = !w_full;
   assign w_push       = bus.in_valid && !w_full;
   // Load decisions use the registered FIFO state, so a same-cycle push is seen one cycle later.
   assign w_load       = !w_empty && ((r_state == IDLE) || (r_timer == DWELL_W'(1)));
   assign w_dwell      = DWELL_W'(eff_dwell(64'(bus.dwell)));
   assign w_shown_nxt  = w_load ? w_head : r_shown;

   led_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (bus.in_data),
      .i_pop   (w_load),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_shown <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (w_load) begin
               r_shown <= w_head;
               r_timer <= w_dwell;
               r_state <= SHOW;
            end
            SHOW: if (r_timer == DWELL_W'(1)) begin
               if (w_load) begin
                  r_shown <= w_head;
                  r_timer <= w_dwell;
               end else begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end
            end else begin
               r_timer <= r_timer - 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.showing = (r_state == SHOW);
   assign bus.done    = r_done;

`ifdef LED_PWM_EN
   logic [3:0]        r_pwm_cnt;
   logic [DATA_W-1:0] r_leds;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_cnt <= '0;
         r_leds    <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         r_leds    <= w_shown_nxt & {DATA_W{r_pwm_cnt < bus.bright}};
      end
   end

   assign bus.leds = r_leds;
`else
   logic [DATA_W-1:0] w_shown_nxt_unused;
   assign w_shown_nxt_unused = w_shown_nxt;
   assign bus.leds           = r_shown;
`endif
endmodule

// File: doc/led_seq_display.md
Name: led_seq_display

Overview:
- Downstream consumer of the Fibonacci value table in the SAP3 LED block.
- Accepts 8-bit values over a valid/ready stream and buffers them in a small FIFO.
- Drives each value onto the board LEDs for a programmable dwell time, in arrival order.
- Signals completion when the buffer drains.

Parameters:
- DATA_W, 8: LED/value width.
- FIFO_DEPTH, 4: buffered entries. Must be a power of 2, ≥ 2.
- DWELL_W, 24: width of the dwell-time input and timer.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  producer has a value.
- IN_DATA  input  DATA_W  value to display.
- IN_READY  output  1  block can accept; transfer occurs when IN_VALID && IN_READY at a rising edge.
- DWELL  input  DWELL_W  cycles each value is shown; sampled at each load.
- LEDS  output  DATA_W  displayed value (registered).
- SHOWING  output  1  high while a value is in its dwell window.
- DONE  output  1  one-cycle pulse when the last buffered value finishes its dwell.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N; all state clears immediately on assertion.
- Reset values:
  - LEDS=0, SHOWING=0, DONE=0.
  - FIFO empty, so IN_READY=1 once reset is asserted.
  - State=IDLE, timer=0.
- IN_READY: equals !full, from the registered FIFO count. No combinational path from IN_VALID.
- FIFO: push on handshake, pop on load.
  - Simultaneous push and pop is legal when not full; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Handshake attempts while full are ignored; the producer holds its data.
- State machine, IDLE:
  - LEDS holds the last shown value; SHOWING=0.
  - If count>0: pop the head, LEDS<=head, timer<=eff_dwell, go SHOW.
- State machine, SHOW:
  - SHOWING=1; timer decrements each cycle.
  - When timer==1 and count>0: pop the next value, reload LEDS and timer, stay in SHOW. Back-to-back values have no gap cycle.
  - When timer==1 and count==0: go IDLE and pulse DONE for exactly one cycle. LEDS keeps the last value.
- Dwell rules:
  - eff_dwell = (DWELL==0) ? 1 : DWELL. Each value is held exactly eff_dwell cycles.
  - DWELL changes mid-window take effect at the next load only.
- Latency: a value accepted at edge k with an empty FIFO and IDLE state appears on LEDS after edge k+1.
- Boundary, push on expiry: a push in the same cycle as expiry with count==0 is not seen by the expiry decision. The block goes IDLE (DONE pulses) and loads that value one cycle later.
- Boundary, reset mid-show: the FIFO is flushed, LEDS clears to 0, and buffered values are discarded.
- Width: the timer is DWELL_W bits and never wraps below 1 in SHOW.

Optional Feature:
- Macro: LED_PWM_EN.
- When defined:
  - Adds input port BRIGHT[3:0] and a free-running 4-bit pwm_cnt, reset to 0.
  - LEDS = shown_value & {DATA_W{pwm_cnt < BRIGHT}}, registered.
  - BRIGHT=0 keeps LEDS dark; BRIGHT=15 gives a 15/16 duty cycle.
  - SHOWING and DONE timing is unchanged.
- When undefined: no BRIGHT port; LEDS shows the value steadily.

Decomposition:
- Package led_pkg:
  - DATA_W and DWELL_W defaults.
  - State enum {IDLE, SHOW}.
  - Function eff_dwell.
- Sub-module led_fifo: synchronous FIFO with parameters DATA_W and FIFO_DEPTH, async active-low reset, and outputs full, empty and count. Reused by other SAP3 display paths.

Test Plan:
- DWELL=3, push 0,1,1,2 back-to-back from IDLE:
  - LEDS = 0,1,1,2, each for exactly 3 cycles, first value after 1 cycle.
  - SHOWING high for 12 contiguous cycles.
  - DONE pulses once, on the cycle after the 12th.
- DWELL=100, push the 8 values 3,5,8,13,21,34,55,89 continuously:
  - Five are accepted (1 showing + 4 buffered), then IN_READY=0.
  - IN_READY rises 1 cycle after each pop; display order is preserved.
- DWELL=0, push 144,233:
  - Each is shown exactly 1 cycle; DONE pulses once.
- DWELL=5 showing 21 with an empty FIFO, push 34 on the expiry cycle:
  - DONE pulses, one IDLE cycle with LEDS=21, then LEDS=34 for 5 cycles.
- Drop RST_N mid-show with 3 entries buffered:
  - LEDS, SHOWING and DONE are immediately 0 and IN_READY=1.
  - After release, no stale value is displayed.
- With LED_PWM_EN, value 0xFF, BRIGHT=4, long DWELL:
  - LEDS=0xFF for 4 of every 16 cycles, 0x00 otherwise.
  - BRIGHT=0 gives constant 0x00.
